// File: rtl/capture_ctrl_pkg.sv
// rtl/capture_ctrl_pkg.sv - shared state encodings and slope constants for the capture front end
package capture_ctrl_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ARMED   = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_DRAIN   = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam logic SLOPE_RISE = 1'b1;
    localparam logic SLOPE_FALL = 1'b0;

    // Acquisition is in flight from arm until the final write has been observed.
    function automatic logic state_busy(input logic [2:0] st);
        return (st == ST_ARMED) || (st == ST_CAPTURE) || (st == ST_DRAIN);
    endfunction

endpackage

// File: rtl/capture_ctrl_if.sv
// rtl/capture_ctrl_if.sv - config, sample input and FIFO write-side bundle for capture_ctrl
interface capture_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 9,
    parameter int DEC_W  = 8
);
    logic              arm_i;
    logic [DATA_W-1:0] level_i;
    logic              slope_i;
    logic [DEC_W-1:0]  decim_i;
    logic [CNT_W-1:0]  length_i;
    logic              force_i;
    logic [DATA_W-1:0] sample_i;
    logic              sample_valid_i;
    logic              fifo_full_i;
    logic              wr_inc_o;
    logic [DATA_W-1:0] wr_data_o;
    logic              busy_o;
    logic              done_o;
    logic              overflow_o;
    logic [2:0]        state_o;

    modport slave (
        input  arm_i, level_i, slope_i, decim_i, length_i, force_i,
        input  sample_i, sample_valid_i, fifo_full_i,
        output wr_inc_o, wr_data_o, busy_o, done_o, overflow_o, state_o
    );

    modport master (
        output arm_i, level_i, slope_i, decim_i, length_i, force_i,
        output sample_i, sample_valid_i, fifo_full_i,
        input  wr_inc_o, wr_data_o, busy_o, done_o, overflow_o, state_o
    );

endinterface

// File: rtl/capture_ctrl_trig_detect.sv
// rtl/capture_ctrl_trig_detect.sv - previous-sample register and level/slope edge compare
module trig_detect
    import capture_ctrl_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic              force_trig,
    input  logic [DATA_W-1:0] cur,
    input  logic [DATA_W-1:0] level,
    input  logic              slope,
    output logic              trig
);

    logic [DATA_W-1:0] prev;
    logic              prev_valid;
    logic              rise_hit;
    logic              fall_hit;
    logic              edge_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev       <= '0;
            prev_valid <= 1'b0;
        end else if (clr) begin
            prev       <= '0;
            prev_valid <= 1'b0;
        end else if (load) begin
            // On a trigger the owner leaves ARMED, so updating prev then is harmless.
            prev       <= cur;
            prev_valid <= 1'b1;
        end
    end

    assign rise_hit = (prev < level) && (cur >= level);
    assign fall_hit = (prev > level) && (cur <= level);
    assign edge_hit = (slope == SLOPE_RISE) ? rise_hit : fall_hit;
    assign trig     = load && (force_trig || (prev_valid && edge_hit));

endmodule

// File: rtl/capture_ctrl.sv
// rtl/capture_ctrl.sv - decimating edge-triggered capture that streams a fixed-length burst into the FIFO
module capture_ctrl
    import capture_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 9,
    parameter int DEC_W  = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    capture_ctrl_if.slave   bus
);

    logic [2:0]        state;
    logic [DATA_W-1:0] level_q;
    logic              slope_q;
    logic [DEC_W-1:0]  decim_q;
    logic [CNT_W-1:0]  length_q;
    logic [DEC_W-1:0]  dec_cnt;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  issue_next;
    logic              last_issue;
    logic              wr_inc;
    logic [DATA_W-1:0] wr_data;
    logic              overflow;
    logic              acquiring;
    logic              take;
    logic              trig;

    assign acquiring  = (state == ST_ARMED) || (state == ST_CAPTURE);
    assign take       = acquiring && bus.sample_valid_i && (dec_cnt == '0) && !bus.arm_i;
    // length 0 encodes a full 2**CNT_W burst through natural counter wrap.
    assign issue_next = issue_cnt + 1'b1;
    assign last_issue = (issue_next == length_q);

    trig_detect #(
        .DATA_W (DATA_W)
    ) u_trig (
        .clk        (clk_i),
        .rst_n      (rst_i),
        .clr        (bus.arm_i),
        .load       (take && (state == ST_ARMED)),
        .force_trig (bus.force_i),
        .cur        (bus.sample_i),
        .level      (level_q),
        .slope      (slope_q),
        .trig       (trig)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            dec_cnt <= '0;
        end else if (bus.arm_i) begin
            dec_cnt <= '0;
        end else if (acquiring && bus.sample_valid_i) begin
            dec_cnt <= (dec_cnt == decim_q) ? '0 : dec_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= ST_IDLE;
            level_q   <= '0;
            slope_q   <= 1'b0;
            decim_q   <= '0;
            length_q  <= '0;
            issue_cnt <= '0;
            wr_inc    <= 1'b0;
            wr_data   <= '0;
            overflow  <= 1'b0;
        end else begin
            wr_inc <= 1'b0;
            if (wr_inc && bus.fifo_full_i) begin
                overflow <= 1'b1;
            end
            if (bus.arm_i) begin
                state     <= ST_ARMED;
                level_q   <= bus.level_i;
                slope_q   <= bus.slope_i;
                decim_q   <= bus.decim_i;
                length_q  <= bus.length_i;
                issue_cnt <= '0;
                overflow  <= 1'b0;
            end else begin
                case (state)
                    ST_ARMED: begin
                        if (trig) begin
                            wr_inc    <= 1'b1;
                            wr_data   <= bus.sample_i;
                            issue_cnt <= issue_next;
                            state     <= last_issue ? ST_DRAIN : ST_CAPTURE;
                        end
                    end
                    ST_CAPTURE: begin
                        if (take) begin
                            wr_inc    <= 1'b1;
                            wr_data   <= bus.sample_i;
                            issue_cnt <= issue_next;
                            if (last_issue) begin
                                state <= ST_DRAIN;
                            end
                        end
                    end
                    ST_DRAIN: state <= ST_DONE;
                    ST_IDLE, ST_DONE: state <= state;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.wr_inc_o   = wr_inc;
    assign bus.wr_data_o  = wr_data;
    assign bus.busy_o     = state_busy(state);
    assign bus.done_o     = (state == ST_DONE);
    assign bus.overflow_o = overflow;
    assign bus.state_o    = state;

endmodule

// File: tb/tb_capture_ctrl.sv
// tb/tb_capture_ctrl.sv - directed-vector bench for capture_ctrl
module tb_capture_ctrl;
    import capture_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    capture_ctrl_if #(.DATA_W(8), .CNT_W(9), .DEC_W(8)) bus ();

    capture_ctrl #(.DATA_W(8), .CNT_W(9), .DEC_W(8)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input logic [7:0] lvl, input logic slp, input logic [7:0] dec, input logic [8:0] len);
        bus.arm_i          = 1'b1;
        bus.level_i        = lvl;
        bus.slope_i        = slp;
        bus.decim_i        = dec;
        bus.length_i       = len;
        bus.sample_valid_i = 1'b0;
        cyc();
        bus.arm_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n              = 1'b0;
        bus.arm_i          = 1'b0;
        bus.level_i        = '0;
        bus.slope_i        = 1'b0;
        bus.decim_i        = '0;
        bus.length_i       = '0;
        bus.force_i        = 1'b0;
        bus.sample_i       = '0;
        bus.sample_valid_i = 1'b0;
        bus.fifo_full_i    = 1'b0;
        #22;
        n_vec++;
        if ({bus.wr_inc_o, bus.wr_data_o, bus.busy_o, bus.done_o, bus.overflow_o, bus.state_o} !== 15'd0) begin
            n_err++;
            $display("FAIL reset_outputs got %h want 0",
                     {bus.wr_inc_o, bus.wr_data_o, bus.busy_o, bus.done_o, bus.overflow_o, bus.state_o});
        end
        #2 rst_n = 1'b1;
        cyc();
        bus.sample_valid_i = 1'b1;
        bus.sample_i       = 8'hFF;
        cyc();
        n_vec++;
        if ({bus.wr_inc_o, bus.state_o} !== {1'b0, ST_IDLE}) begin
            n_err++;
            $display("FAIL idle_ignores_samples inc/state got %b/%0d want 0/0", bus.wr_inc_o, bus.state_o);
        end
        bus.sample_valid_i = 1'b0;
    endtask

    task automatic test_rising();
        logic [7:0] smp [7] = '{8'h10, 8'h70, 8'h90, 8'hA0, 8'hB0, 8'hC0, 8'hD0};
        logic       ei  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [2:0] es  [7] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd4};
        do_arm(8'h80, SLOPE_RISE, 8'd0, 9'd4);
        n_vec++;
        if ({bus.state_o, bus.busy_o} !== {ST_ARMED, 1'b1}) begin
            n_err++;
            $display("FAIL rise_armed state/busy got %0d/%b want 1/1", bus.state_o, bus.busy_o);
        end
        for (int i = 0; i < 7; i++) begin
            bus.sample_i       = smp[i];
            bus.sample_valid_i = 1'b1;
            cyc();
            n_vec++;
            if ({bus.wr_inc_o, bus.state_o} !== {ei[i], es[i]}) begin
                n_err++;
                $display("FAIL rise_step%0d inc/state got %b/%0d want %b/%0d", i, bus.wr_inc_o, bus.state_o, ei[i], es[i]);
            end
            if (ei[i]) begin
                n_vec++;
                if (bus.wr_data_o !== smp[i]) begin
                    n_err++;
                    $display("FAIL rise_data%0d got %h want %h", i, bus.wr_data_o, smp[i]);
                end
            end
        end
        bus.sample_valid_i = 1'b0;
        n_vec++;
        if ({bus.done_o, bus.overflow_o, bus.busy_o, bus.wr_data_o} !== {1'b1, 1'b0, 1'b0, 8'hC0}) begin
            n_err++;
            $display("FAIL rise_done done/ovf/busy/data got %b/%b/%b/%h want 1/0/0/c0",
                     bus.done_o, bus.overflow_o, bus.busy_o, bus.wr_data_o);
        end
    endtask

    task automatic test_falling_decim();
        logic [7:0] val;
        logic       ei;
        logic [2:0] es;
        do_arm(8'h40, SLOPE_FALL, 8'd2, 9'd2);
        for (int i = 0; i < 10; i++) begin
            val = 8'h60 - 8'(8 * i);
            ei  = (i == 6) || (i == 9);
            es  = (i < 6) ? ST_ARMED : (i < 9) ? ST_CAPTURE : ST_DRAIN;
            bus.sample_i       = val;
            bus.sample_valid_i = 1'b1;
            cyc();
            n_vec++;
            if ({bus.wr_inc_o, bus.state_o} !== {ei, es}) begin
                n_err++;
                $display("FAIL fall_valid%0d inc/state got %b/%0d want %b/%0d", i, bus.wr_inc_o, bus.state_o, ei, es);
            end
            if (ei) begin
                n_vec++;
                if (bus.wr_data_o !== val) begin
                    n_err++;
                    $display("FAIL fall_data%0d got %h want %h", i, bus.wr_data_o, val);
                end
            end
            bus.sample_valid_i = 1'b0;
            cyc();
            n_vec++;
            if ({bus.wr_inc_o, bus.state_o} !== {1'b0, (i == 9) ? ST_DONE : es}) begin
                n_err++;
                $display("FAIL fall_gap%0d inc/state got %b/%0d want 0/%0d", i, bus.wr_inc_o, bus.state_o,
                         (i == 9) ? ST_DONE : es);
            end
        end
    endtask

    task automatic test_force();
        do_arm(8'hFF, SLOPE_RISE, 8'd0, 9'd1);
        bus.force_i        = 1'b1;
        bus.sample_i       = 8'h33;
        bus.sample_valid_i = 1'b1;
        cyc();
        n_vec++;
        if ({bus.wr_inc_o, bus.wr_data_o, bus.state_o} !== {1'b1, 8'h33, ST_DRAIN}) begin
            n_err++;
            $display("FAIL force_trigger inc/data/state got %b/%h/%0d want 1/33/3", bus.wr_inc_o, bus.wr_data_o, bus.state_o);
        end
        bus.force_i  = 1'b0;
        bus.sample_i = 8'h44;
        cyc();
        n_vec++;
        if ({bus.wr_inc_o, bus.wr_data_o, bus.done_o} !== {1'b0, 8'h33, 1'b1}) begin
            n_err++;
            $display("FAIL force_done inc/data/done got %b/%h/%b want 0/33/1", bus.wr_inc_o, bus.wr_data_o, bus.done_o);
        end
        bus.sample_valid_i = 1'b0;
    endtask

    task automatic test_overflow();
        logic [7:0] smp [4] = '{8'h00, 8'h90, 8'h91, 8'h92};
        logic       ef  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic       ei  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic       eo  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [2:0] es  [4] = '{3'd1, 3'd2, 3'd2, 3'd3};
        do_arm(8'h80, SLOPE_RISE, 8'd0, 9'd3);
        for (int i = 0; i < 4; i++) begin
            bus.fifo_full_i    = ef[i];
            bus.sample_i       = smp[i];
            bus.sample_valid_i = 1'b1;
            cyc();
            n_vec++;
            if ({bus.wr_inc_o, bus.overflow_o, bus.state_o} !== {ei[i], eo[i], es[i]}) begin
                n_err++;
                $display("FAIL ovf_step%0d inc/ovf/state got %b/%b/%0d want %b/%b/%0d", i,
                         bus.wr_inc_o, bus.overflow_o, bus.state_o, ei[i], eo[i], es[i]);
            end
        end
        bus.fifo_full_i    = 1'b0;
        bus.sample_valid_i = 1'b0;
        cyc();
        n_vec++;
        if ({bus.done_o, bus.overflow_o, bus.wr_inc_o} !== 3'b110) begin
            n_err++;
            $display("FAIL ovf_done done/ovf/inc got %b/%b/%b want 1/1/0", bus.done_o, bus.overflow_o, bus.wr_inc_o);
        end
        do_arm(8'h80, SLOPE_RISE, 8'd0, 9'd3);
        n_vec++;
        if ({bus.overflow_o, bus.state_o} !== {1'b0, ST_ARMED}) begin
            n_err++;
            $display("FAIL ovf_rearm ovf/state got %b/%0d want 0/1", bus.overflow_o, bus.state_o);
        end
    endtask

    task automatic test_rearm_mid_capture();
        logic [7:0] smp [8] = '{8'h00, 8'h90, 8'h91, 8'hA0, 8'hA0, 8'hB0, 8'h10, 8'h90};
        logic       ef  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       ea  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       ei  [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       eo  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [2:0] es  [8] = '{3'd1, 3'd2, 3'd2, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2};
        do_arm(8'h80, SLOPE_RISE, 8'd0, 9'd8);
        for (int i = 0; i < 8; i++) begin
            bus.arm_i          = ea[i];
            bus.fifo_full_i    = ef[i];
            bus.sample_i       = smp[i];
            bus.sample_valid_i = 1'b1;
            cyc();
            n_vec++;
            if ({bus.wr_inc_o, bus.overflow_o, bus.state_o} !== {ei[i], eo[i], es[i]}) begin
                n_err++;
                $display("FAIL rearm_step%0d inc/ovf/state got %b/%b/%0d want %b/%b/%0d", i,
                         bus.wr_inc_o, bus.overflow_o, bus.state_o, ei[i], eo[i], es[i]);
            end
        end
        bus.arm_i = 1'b0;
        n_vec++;
        if (bus.wr_data_o !== 8'h90) begin
            n_err++;
            $display("FAIL rearm_data got %h want 90", bus.wr_data_o);
        end
    endtask

    task automatic test_async_reset();
        bus.sample_i       = 8'h95;
        bus.sample_valid_i = 1'b1;
        cyc();
        n_vec++;
        if ({bus.wr_inc_o, bus.state_o} !== {1'b1, ST_CAPTURE}) begin
            n_err++;
            $display("FAIL areset_pre inc/state got %b/%0d want 1/2", bus.wr_inc_o, bus.state_o);
        end
        #3 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.wr_inc_o, bus.wr_data_o, bus.busy_o, bus.done_o, bus.overflow_o, bus.state_o} !== 15'd0) begin
            n_err++;
            $display("FAIL areset_outputs got %h want 0",
                     {bus.wr_inc_o, bus.wr_data_o, bus.busy_o, bus.done_o, bus.overflow_o, bus.state_o});
        end
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.sample_valid_i = i[0];
            bus.sample_i       = 8'hC0;
            cyc();
            n_vec++;
            if ({bus.wr_inc_o, bus.busy_o, bus.state_o} !== {1'b0, 1'b0, ST_IDLE}) begin
                n_err++;
                $display("FAIL areset_idle%0d inc/busy/state got %b/%b/%0d want 0/0/0", i,
                         bus.wr_inc_o, bus.busy_o, bus.state_o);
            end
        end
        bus.sample_valid_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rising();
        test_falling_decim();
        test_force();
        test_overflow();
        test_rearm_mid_capture();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
- Acquisition front end sitting directly upstream of the async FIFO write side, in the sample clock domain.
- Takes raw ADC samples and applies decimation and an edge trigger with level and slope.
- After the trigger, streams a fixed-length capture into the FIFO as write strobe plus data.
- Tracks FIFO refusals using the FIFO full flag, so software can tell whether the capture is intact.

Parameters:
- DATA_W, 8: ADC sample width.
- CNT_W, 9: capture length counter width. Matches FIFO ADDR_SIZE+1, so a full FIFO depth is expressible.
- DEC_W, 8: decimation ratio width.

Ports:
- clk_i  in  1  sample clock.
- rst_i  in  1  asynchronous active-low reset.
- arm_i  in  1  one-cycle pulse; latches config, (re)starts acquisition from any state.
- level_i  in  DATA_W  trigger level (unsigned), latched on arm.
- slope_i  in  1  1 = rising, 0 = falling; latched on arm.
- decim_i  in  DEC_W  keep 1 of (decim_i+1) valid samples; latched on arm.
- length_i  in  CNT_W  samples per capture; 0 means 2**CNT_W; latched on arm.
- force_i  in  1  force trigger on the next taken sample while ARMED.
- sample_i  in  DATA_W  ADC sample.
- sample_valid_i  in  1  sample_i valid this cycle.
- fifo_full_i  in  1  FIFO full flag, same clock domain.
- wr_inc_o  out  1  FIFO write strobe.
- wr_data_o  out  DATA_W  FIFO write data.
- busy_o  out  1  high in ARMED, CAPTURE, DRAIN.
- done_o  out  1  high in DONE.
- overflow_o  out  1  sticky; at least one write was refused this capture.
- state_o  out  3  current state encoding.

Behaviour:
Reset:
- state IDLE; all outputs 0.
- Internal registers cleared: decimation counter, prev sample, prev_valid, issue counter.

States (encoding): IDLE=0, ARMED=1, CAPTURE=2, DRAIN=3, DONE=4. Priority: arm_i over every other event.
- arm_i in any state: at the next edge, state ARMED. Latch level/slope/decim/length. Clear decimation counter, prev_valid, issue counter and overflow_o. A sample taken in the arm cycle is discarded.

Taken sample: sample_valid_i=1 and dec_cnt==0, in ARMED or CAPTURE only.
- dec_cnt advances on every valid sample, wrapping to 0 after reaching the latched decim.
- decim=0 means every valid sample is taken.

ARMED:
- First taken sample only loads prev and sets prev_valid.
- Rising trigger: prev_valid, prev < level, and cur >= level.
- Falling trigger: prev_valid, prev > level, and cur <= level.
- force_i high in a cycle with a taken sample triggers, with or without prev_valid. force_i outside ARMED is ignored.
- When there is no trigger, prev takes cur.
- On trigger: next edge gives state CAPTURE, wr_inc_o=1 and wr_data_o=cur. The trigger sample is capture sample 1.

CAPTURE:
- Every taken sample is issued: wr_inc_o pulses for one cycle, one cycle after the take, with wr_data_o=sample. Latency is exactly 1.
- Issues are unconditional. The issue counter increments per issue.
- When the issue counter reaches the latched length (mod 2**CNT_W), state becomes DRAIN at the edge that raises the final wr_inc_o.
- For length=1: ARMED goes straight to DRAIN on trigger.

Acceptance:
- A write is refused when wr_inc_o=1 and fifo_full_i=1 in the same cycle; this is the exact FIFO write-side rule.
- A refusal sets overflow_o at the next edge. overflow_o stays set until the next arm.

DRAIN:
- One cycle, covering the final wr_inc_o. Lets that write's acceptance be observed.
- Then DONE.

DONE:
- done_o=1 and wr_inc_o=0. Holds until arm_i.

Other rules:
- wr_inc_o is never high in IDLE or DONE, and never two cycles in a row without two takes.
- wr_data_o holds its last value when wr_inc_o=0.
- IDLE only leaves on arm_i; sample_valid_i is ignored there.

Decomposition:
- Shared include: state encodings (ST_IDLE..ST_DONE) and the slope constants SLOPE_RISE=1, SLOPE_FALL=0.
- Sub-module trig_detect: prev/prev_valid registers plus the level/slope compare. It takes a load enable and outputs a trig pulse.
- Decimation counter and FSM stay in capture_ctrl.

Test Plan:
- Arm with level=0x80, rising, decim=0, length=4. Feed 0x10,0x70,0x90,0xA0,0xB0,0xC0,0xD0 continuously. Expect exactly 4 wr_inc_o pulses with data 0x90,0xA0,0xB0,0xC0, each 1 cycle after its sample. Then DRAIN, then done_o=1, overflow_o=0.
- Falling, level=0x40, decim=2. Feed ramp 0x60 down by 0x08 per valid. Expect only every 3rd valid sample compared. Expect trigger on the first taken sample <=0x40 with prev >0x40.
- force_i=1 on the first valid after arm with level=0xFF. Expect immediate trigger on that sample and wr_data_o equal to it.
- length=3, fifo_full_i held 1 during the 2nd wr_inc_o. Expect 3 issues, overflow_o rising 1 cycle after the refused strobe, done_o=1 with overflow_o=1. Re-arm clears overflow_o.
- arm_i pulsed mid-CAPTURE (after 2 of 8 issues). Expect no wr_inc_o from the arm-cycle sample, state ARMED next cycle, overflow_o cleared, and a fresh trigger required.
- rst_i asserted asynchronously mid-CAPTURE. Expect all outputs 0 immediately and state_o=0. After release, remains IDLE with sample_valid_i toggling.
